shift_register_controller: RTL and testbench

Sequencer for the 4-bit universal shift register (opcode-driven hold/shift-right/shift-left/parallel-load datapath).
- Accepts a start request carrying an operand, direction, shift count and fill mode.
- Drives the register's opcode, parallel data and serial inputs cycle by cycle.
- Reads back the register contents, reports the result with a one-cycle done pulse, and parks the register in hold when idle.

---
 rtl/shift_register_controller_pkg.sv | 22 ++
 rtl/shift_register_controller_count.sv | 35 +++
 rtl/shift_register_controller.sv | 137 +++++++++++++
 tb/tb_shift_register_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_register_controller_pkg.sv
// Shared definitions for blocks that drive the 4-bit universal shift register.
//   - Opcode constants understood by the register (hold/shift-right/shift-left/load).
//   - State encodings of the shift_register_controller sequencer.
//   - Default datapath and shift-count widths.
package shift_register_controller_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  // Register opcodes
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Sequencer states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/shift_register_controller_count.sv
// shift_count_down: CNT_W-bit loadable down-counter that tells the sequencer
// when the final shift cycle is in progress.
// Ports:
//   clk   in   clock
//   clear in   synchronous active-high reset (counter -> 0)
//   load  in   load din (takes priority over dec)
//   dec   in   decrement by one; never wraps below zero
//   din   in   CNT_W  value to load
//   last  out  high while the counter reads exactly 1
module shift_count_down #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] din,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/shift_register_controller.sv
// shift_register_controller: sequencer for the 4-bit universal shift register.
// A start request latches an operand, direction, shift count and fill mode;
// the controller then loads the register, shifts it count times and captures
// the readback into result with a one-cycle done pulse.
// Ports:
//   clk          in   system clock
//   clear        in   synchronous active-high reset
//   start        in   request, sampled only in IDLE
//   load_data    in   WIDTH operand
//   dir          in   0 = shift right, 1 = shift left
//   count        in   CNT_W number of shift cycles
//   rotate       in   0 = logical fill from serial_in, 1 = rotate
//   serial_in    in   fill bit for logical shifts
//   sr_q         in   WIDTH register readback
//   opcode       out  2-bit register opcode
//   sr_data      out  WIDTH parallel load data
//   sr_in_right  out  serial bit entering MSB on a right shift
//   sr_in_left   out  serial bit entering LSB on a left shift
//   serial_out   out  bit leaving the register during SHIFT
//   busy         out  high in LOAD and SHIFT
//   done         out  one-cycle pulse in DONE
//   result       out  WIDTH register contents captured in DONE
module shift_register_controller
  import shift_register_controller_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic             rotate,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       opcode,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_in_right,
  output logic             sr_in_left,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] lat_data;
  logic             lat_dir;
  logic [CNT_W-1:0] lat_cnt;
  logic             lat_rot;
  logic             cnt_last;

  // The counter is loaded during LOAD so that it holds count on the first
  // SHIFT cycle; the cycle on which it reads 1 is the final shift.
  shift_count_down #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .clear (clear),
    .load  (state == S_LOAD),
    .dec   (state == S_SHIFT),
    .din   (lat_cnt),
    .last  (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (lat_cnt != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= S_IDLE;
      lat_data <= '0;
      lat_dir  <= 1'b0;
      lat_cnt  <= '0;
      lat_rot  <= 1'b0;
      result   <= '0;
    end else begin
      state <= state_nxt;
      // Request fields are frozen at acceptance; later input changes are ignored.
      if (state == S_IDLE && start) begin
        lat_data <= load_data;
        lat_dir  <= dir;
        lat_cnt  <= count;
        lat_rot  <= rotate;
      end
      if (state == S_DONE) begin
        result <= sr_q;
      end
    end
  end

  // Moore decode; only the serial paths look at the live register contents.
  always_comb begin
    opcode      = OP_HOLD;
    sr_data     = '0;
    sr_in_right = 1'b0;
    sr_in_left  = 1'b0;
    serial_out  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_LOAD: begin
        opcode  = OP_LOAD;
        sr_data = lat_data;
        busy    = 1'b1;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (lat_dir) begin
          opcode     = OP_SHL;
          sr_in_left = lat_rot ? sr_q[WIDTH-1] : serial_in;
          serial_out = sr_q[WIDTH-1];
        end else begin
          opcode      = OP_SHR;
          sr_in_right = lat_rot ? sr_q[0] : serial_in;
          serial_out  = sr_q[0];
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        opcode = OP_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_register_controller.sv
module tb_shift_register_controller;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [3:0] load_data = '0;
  logic       dir = 1'b0;
  logic [2:0] count = '0;
  logic       rotate = 1'b0;
  logic       serial_in = 1'b0;
  logic [3:0] sr_q = '0;
  logic [1:0] opcode;
  logic [3:0] sr_data;
  logic       sr_in_right;
  logic       sr_in_left;
  logic       serial_out;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int n_chk = 0;
  int n_pass = 0;
  int fills [0:7];

  shift_register_controller dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .load_data   (load_data),
    .dir         (dir),
    .count       (count),
    .rotate      (rotate),
    .serial_in   (serial_in),
    .sr_q        (sr_q),
    .opcode      (opcode),
    .sr_data     (sr_data),
    .sr_in_right (sr_in_right),
    .sr_in_left  (sr_in_left),
    .serial_out  (serial_out),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  // Universal shift register being controlled (not cleared by the controller).
  always @(posedge clk) begin
    case (opcode)
      2'b01:   sr_q <= {sr_in_right, sr_q[3:1]};
      2'b10:   sr_q <= {sr_q[2:0], sr_in_left};
      2'b11:   sr_q <= sr_data;
      default: sr_q <= sr_q;
    endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Register contents after n shifts of operand d, from closed-form rules:
  // rotation by n mod 4, or a logical shift where fills[k] is the k-th fill bit.
  function automatic int model(input int d, input bit dr, input bit rot, input int n);
    int w;
    int r;
    if (rot) begin
      r = n % 4;
      if (dr) w = (d << r) | (d >> (4 - r));
      else    w = (d >> r) | (d << (4 - r));
      return w & 15;
    end
    if (dr) begin
      w = d << n;
      for (int k = 0; k < n; k++) w = w | (fills[k] << (n - 1 - k));
    end else begin
      w = d;
      for (int k = 0; k < n; k++) w = w | (fills[k] << (4 + k));
      w = w >> n;
    end
    return w & 15;
  endfunction

  // Runs one operation from IDLE and returns in the IDLE cycle after DONE.
  // sin: 0/1 fixed serial_in, 2 random. hold: leave start asserted throughout.
  task automatic run_op(input int d, input bit dr, input int n, input bit rot,
                        input int sin, input bit hold);
    int cur;
    load_data = 4'(d);
    dir       = dr;
    count     = 3'(n);
    rotate    = rot;
    start     = 1'b1;
    #1;
    chk("idle_opcode", opcode, 0);
    chk("idle_busy", busy, 0);
    step();
    if (!hold) start = 1'b0;
    load_data = 4'($urandom);
    dir       = 1'($urandom);
    count     = 3'($urandom);
    rotate    = 1'($urandom);
    #1;
    chk("load_opcode", opcode, 3);
    chk("load_data", sr_data, d);
    chk("load_busy", busy, 1);
    chk("load_done", done, 0);
    for (int k = 0; k < n; k++) begin
      step();
      serial_in = (sin == 2) ? 1'($urandom) : 1'(sin);
      fills[k] = int'(serial_in);
      #1;
      cur = model(d, dr, rot, k);
      chk("shift_opcode", opcode, dr ? 2 : 1);
      chk("shift_busy", busy, 1);
      chk("shift_done", done, 0);
      chk("serial_out", serial_out, dr ? ((cur >> 3) & 1) : (cur & 1));
      chk("in_right", sr_in_right, dr ? 0 : (rot ? (cur & 1) : fills[k]));
      chk("in_left", sr_in_left, dr ? (rot ? ((cur >> 3) & 1) : fills[k]) : 0);
    end
    step();
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_opcode", opcode, 0);
    step();
    chk("idle_done", done, 0);
    chk("result", result, model(d, dr, rot, n));
  endtask

  initial begin
    // Reset
    clear = 1'b1;
    step();
    step();
    clear = 1'b0;
    #1;
    chk("rst_opcode", opcode, 0);
    chk("rst_sr_data", sr_data, 0);
    chk("rst_in_right", sr_in_right, 0);
    chk("rst_in_left", sr_in_left, 0);
    chk("rst_serial_out", serial_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);

    // Directed operations
    run_op(4'b1100, 1'b0, 2, 1'b0, 0, 1'b0);
    chk("dir_res1", result, 4'b0011);
    run_op(4'b1001, 1'b1, 1, 1'b1, 2, 1'b0);
    chk("dir_res2", result, 4'b0011);
    run_op(4'b1011, 1'b0, 4, 1'b1, 2, 1'b0);
    chk("dir_res3", result, 4'b1011);
    run_op(4'b1010, 1'b1, 6, 1'b0, 1, 1'b0);
    chk("dir_res4", result, 4'b1111);
    run_op(4'b1100, 1'b0, 0, 1'b0, 2, 1'b0);
    chk("dir_res5", result, 4'b1100);

    // Abort: count 7, second start during SHIFT, clear in the 3rd SHIFT cycle
    load_data = 4'b0110; dir = 1'b0; count = 3'd7; rotate = 1'b1; start = 1'b1;
    step();              // LOAD
    start = 1'b0;
    step();              // SHIFT 1
    start = 1'b1; load_data = 4'b0001;
    step();              // SHIFT 2
    #1;
    chk("abort_ignored_start", opcode, 1);
    step();              // SHIFT 3
    clear = 1'b1; start = 1'b0;
    #1;
    chk("abort_shift3", opcode, 1);
    step();
    clear = 1'b0;
    #1;
    chk("abort_opcode", opcode, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    step();
    chk("abort_stays_idle", opcode, 0);
    chk("abort_busy2", busy, 0);

    // start held continuously, count = 1
    for (int i = 0; i < 4; i++) begin
      run_op(int'($urandom_range(0, 15)), 1'($urandom), 1, 1'($urandom), 2, 1'b1);
    end
    start = 1'b0;
    step();

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      run_op(int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 7)),
             1'($urandom), 2, 1'b0);
      if ($urandom_range(0, 2) == 0) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
